// File: rtl/dso_uart_pkg.sv
// Shared types and constants for the DSO command-link UART slave.
package dso_uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_XMIT = 1'b1
  } tx_state_t;

  localparam int BYTES_PER_CMD = 3;
  localparam int FRAME_BITS    = 10;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: RX synchronizer, falling-edge detect, bit-timing FSM.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | half a bit after the edge; high here means glitch
// RX_DATA  | sampling 8 data bits LSB first, one per bit period
// RX_STOP  | sampling stop bit; high accepts the byte, low is framing error
module uart_rx_core
  import dso_uart_pkg::*;
#(
  parameter int BAUD_DIV = 4340
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic       rx_start,
  output logic       rx_ferr,
  output logic       rx_idle
);

  localparam int CNT_W = $clog2(BAUD_DIV);

  rx_state_t        state;
  logic             rx_s1, rx_s2, rx_prev;
  logic             rx_fall;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;

  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_idle = (state == RX_IDLE);

  // Two-flop synchronizer plus one delay stage for edge detection; preset to idle-high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receive FSM with bit-period down-counter; sample when the counter reaches zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_byte  <= '0;
      rx_vld   <= 1'b0;
      rx_start <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_vld   <= 1'b0;
      rx_start <= 1'b0;
      rx_ferr  <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          if (rx_fall) begin
            state    <= RX_START;
            cnt      <= CNT_W'(BAUD_DIV / 2 - 1);
            rx_start <= 1'b1;
          end
        end
        RX_START: begin
          if (cnt == '0) begin
            if (rx_s2) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              cnt     <= CNT_W'(BAUD_DIV - 1);
              bit_cnt <= '0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_s2, shreg[7:1]};
            cnt   <= CNT_W'(BAUD_DIV - 1);
            if (bit_cnt == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == '0) begin
            state <= RX_IDLE;
            if (rx_s2) begin
              rx_vld  <= 1'b1;
              rx_byte <= shreg;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_slv.sv
// UART command slave: three received bytes form one 24-bit command,
// 8-bit responses are serialized back. RX and TX run independently.
//
// state   | meaning
// --------+--------------------------------------------------
// TX_IDLE | TX held high, waiting for send_resp
// TX_XMIT | shifting {stop, resp, start} out, one bit per BAUD_DIV
module uart_cmd_slv
  import dso_uart_pkg::*;
#(
  parameter int BAUD_DIV = 4340,
  parameter int TMO_BITS = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam int TMO_CLKS = TMO_BITS * BAUD_DIV;
  localparam int TMO_W    = $clog2(TMO_CLKS);

  logic [7:0]       rx_byte;
  logic             rx_vld, rx_start, rx_ferr, rx_idle;
  logic [15:0]      hold;
  logic [1:0]       idx;
  logic             cmd_load;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_run, tmo_hit;
  tx_state_t        tx_state;
  logic [9:0]       tx_sh;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;

  uart_rx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (RX),
    .rx_byte  (rx_byte),
    .rx_vld   (rx_vld),
    .rx_start (rx_start),
    .rx_ferr  (rx_ferr),
    .rx_idle  (rx_idle)
  );

  assign cmd_load = rx_vld && (idx == 2'(BYTES_PER_CMD - 1));
  assign tmo_run  = (idx != 2'd0) && rx_idle;
  assign tmo_hit  = tmo_run && (tmo_cnt == '0);

  // Command assembly: first two bytes shift into hold, third loads cmd
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      idx  <= '0;
      cmd  <= '0;
    end else if (rx_ferr) begin
      idx <= '0;
    end else if (rx_vld) begin
      if (cmd_load) begin
        cmd <= {hold, rx_byte};
        idx <= '0;
      end else begin
        hold <= {hold[7:0], rx_byte};
        idx  <= idx + 2'd1;
      end
    end else if (tmo_hit) begin
      idx <= '0;
    end
  end

  // cmd_rdy: a new command outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_rdy <= 1'b0;
    end else if (cmd_load) begin
      cmd_rdy <= 1'b1;
    end else if (clr_cmd_rdy || rx_start) begin
      cmd_rdy <= 1'b0;
    end
  end

  // Inter-byte timeout: reloads whenever no partial command is waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= TMO_W'(TMO_CLKS - 1);
    end else if (!tmo_run) begin
      tmo_cnt <= TMO_W'(TMO_CLKS - 1);
    end else if (tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - TMO_W'(1);
    end
  end

  // Transmit FSM: TX comes straight from the shift-register LSB, so it is glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_sh     <= '1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      resp_sent <= 1'b0;
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_state  <= TX_XMIT;
            tx_sh     <= {1'b1, resp, 1'b0};
            tx_cnt    <= CNT_W'(BAUD_DIV - 1);
            tx_bit    <= '0;
            resp_sent <= 1'b0;
          end
        end
        TX_XMIT: begin
          if (tx_cnt == '0) begin
            tx_cnt <= CNT_W'(BAUD_DIV - 1);
            tx_sh  <= {1'b1, tx_sh[9:1]};
            if (tx_bit == 4'(FRAME_BITS - 1)) begin
              tx_state  <= TX_IDLE;
              resp_sent <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 4'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - CNT_W'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign TX = tx_sh[0];

endmodule

// File: tb/tb_uart_cmd_slv.sv
// Bench for uart_cmd_slv: drives 8N1 frames on RX, checks assembled
// commands against a byte-queue model and TX frames against {1,resp,0}.
module tb_uart_cmd_slv;

  localparam int BAUD     = 32;
  localparam int TMO      = 40;
  // 1-based posedge count (from start-bit drive) of the stop-bit sample edge
  localparam int STOP_CNT = 2 + BAUD / 2 + 9 * BAUD + 1;

  logic        clk;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  int          n_cmp;
  int          n_err;
  logic [7:0]  q[$];
  logic [23:0] exp_cmd;
  bit          fired;

  uart_cmd_slv #(
    .BAUD_DIV (BAUD),
    .TMO_BITS (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: accepted bytes queue up; every third byte forms a command
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      q.delete();
    end else begin
      q.push_back(b);
      if (q.size() == 3) begin
        exp_cmd = {q[0], q[1], q[2]};
        q.delete();
        fired = 1'b1;
      end
    end
  endtask

  task automatic gap(input int bits);
    RX = 1'b1;
    repeat (bits * BAUD) tick();
    if (bits >= TMO) q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_hi,
                           output bit r_pre, output bit r_post, output logic [23:0] c_post);
    logic [9:0] fr;
    int n;
    fr = {stop_hi, b, 1'b0};
    r_pre = 1'b0; r_post = 1'b0; c_post = '0; n = 0;
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      for (int j = 0; j < BAUD; j++) begin
        tick();
        n++;
        if (n == STOP_CNT) r_pre = cmd_rdy;
        if (n == STOP_CNT + 1) begin
          r_post = cmd_rdy;
          c_post = cmd;
        end
      end
    end
  endtask

  task automatic send_m(input logic [7:0] b, input bit ok, input string tag);
    bit r0, r1;
    logic [23:0] c1;
    send_byte(b, ok, r0, r1, c1);
    model_byte(b, ok);
    if (fired) begin
      chk({tag, "_rdy_at_stop"}, 32'(r0), 32'd0);
      chk({tag, "_rdy_after_stop"}, 32'(r1), 32'd1);
      chk({tag, "_cmd_at_rdy"}, 32'(c1), 32'(exp_cmd));
      fired = 1'b0;
    end
    chk({tag, "_cmd_hold"}, 32'(cmd), 32'(exp_cmd));
  endtask

  task automatic tx_frame(input logic [7:0] r, input bit poke, input string tag);
    logic [9:0] fr;
    fr = {1'b1, r, 1'b0};
    resp = r;
    send_resp = 1'b1;
    for (int n = 1; n <= 10 * BAUD + 1; n++) begin
      tick();
      if (n == 1) begin
        send_resp = 1'b0;
        chk({tag, "_sent_clr"}, 32'(resp_sent), 32'd0);
      end
      if (poke && n == 99) begin
        send_resp = 1'b1;
        resp = ~r;
      end
      if (poke && n == 100) send_resp = 1'b0;
      if (n % BAUD == BAUD / 2 + 1) chk({tag, "_tx_bit"}, 32'(TX), 32'(fr[(n - 1) / BAUD]));
      if (n == 10 * BAUD) chk({tag, "_sent_early"}, 32'(resp_sent), 32'd0);
      if (n == 10 * BAUD + 1) begin
        chk({tag, "_sent_rise"}, 32'(resp_sent), 32'd1);
        chk({tag, "_tx_idle"}, 32'(TX), 32'd1);
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    bit r0, r1;
    logic [23:0] c1;
    n_cmp = 0; n_err = 0; exp_cmd = '0; fired = 1'b0;
    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; resp = '0; send_resp = 1'b0;

    // reset values
    repeat (3) tick();
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_resp_sent", 32'(resp_sent), 32'd0);
    rst_n = 1'b1;
    gap(2);

    // basic command and acknowledge
    send_m(8'h02, 1'b1, "c1b0"); gap(1);
    send_m(8'h00, 1'b1, "c1b1"); gap(1);
    send_m(8'h0B, 1'b1, "c1b2");
    chk("c1_value", 32'(cmd), 32'h02000B);
    repeat (5) tick();
    chk("c1_rdy_held", 32'(cmd_rdy), 32'd1);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("c1_rdy_cleared", 32'(cmd_rdy), 32'd0);

    // response frame, second request during transmission ignored
    tx_frame(8'hA5, 1'b1, "txA5");
    repeat (10) tick();
    chk("txA5_sent_hold", 32'(resp_sent), 32'd1);

    // timeout discards a lone byte
    send_m(8'h04, 1'b1, "tmo_b"); gap(41);
    send_m(8'h01, 1'b1, "tmo_c0"); gap(1);
    send_m(8'h02, 1'b1, "tmo_c1"); gap(1);
    send_m(8'h03, 1'b1, "tmo_c2");
    chk("tmo_value", 32'(cmd), 32'h010203);
    gap(2);

    // framing error drops the partial command
    send_m(8'h5A, 1'b1, "fe_pre"); gap(1);
    send_m(8'h77, 1'b0, "fe_bad"); gap(2);
    send_m(8'hAA, 1'b1, "fe_c0"); gap(1);
    send_m(8'hBB, 1'b1, "fe_c1"); gap(1);
    send_m(8'hCC, 1'b1, "fe_c2");
    chk("fe_value", 32'(cmd), 32'hAABBCC);
    gap(2);

    // short low glitch produces no byte
    RX = 1'b0;
    repeat (5) tick();
    gap(3);
    chk("gl_cmd_hold", 32'(cmd), 32'(exp_cmd));
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      send_m(b, 1'b1, "gl_c");
      gap(int'($urandom_range(2, 0)));
    end

    // set and clear in the same cycle: set wins
    clr_cmd_rdy = 1'b1;
    send_m(8'($urandom), 1'b1, "sw_c0");
    send_m(8'($urandom), 1'b1, "sw_c1");
    send_m(8'($urandom), 1'b1, "sw_c2");
    chk("sw_rdy_cleared", 32'(cmd_rdy), 32'd0);
    clr_cmd_rdy = 1'b0;
    gap(2);

    // reset during byte 2 loses the partial command
    send_m(8'h3C, 1'b1, "rs_b0"); gap(1);
    fork
      send_byte(8'hC3, 1'b1, r0, r1, c1);
      begin
        repeat (150) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        chk("rs_cmd", 32'(cmd), 32'd0);
        chk("rs_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("rs_tx", 32'(TX), 32'd1);
        repeat (148) tick();
        rst_n = 1'b1;
      end
    join
    q.delete();
    exp_cmd = '0;
    gap(2);
    send_m(8'($urandom), 1'b1, "rs_c0"); gap(1);
    send_m(8'($urandom), 1'b1, "rs_c1"); gap(1);
    send_m(8'($urandom), 1'b1, "rs_c2");
    gap(1);

    // full duplex: random commands with random gaps while responses go out
    for (int it = 0; it < 3; it++) begin
      fork
        begin
          for (int k = 0; k < 3; k++) begin
            send_m(8'($urandom), 1'b1, "fd_c");
            gap(int'($urandom_range(3, 0)));
          end
        end
        tx_frame(8'($urandom), 1'b0, "fd_tx");
      join
      gap(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
